// File: rtl/c17_pipe_array.sv
// c17_pipe_array: LANES parallel ISCAS c17 cells feeding a DEPTH-stage valid/ready pipeline
// Ports: clk (rising edge), rn (async active-low reset), vdd/gnd (supply pass-through),
//        in_data/in_valid/in_ready (upstream, 5 bits per lane = {I7,I6,I3,I2,I1}),
//        out_data/out_valid/out_ready (downstream, 2 bits per lane = {O23,O22}),
//        flush (sync clear), cnt (output handshake count),
//        sig (output MISR signature, only when C17_MISR_EN is defined)
module c17_pipe_array #(
  parameter int LANES = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rn,
  inout  wire                  vdd,
  inout  wire                  gnd,
  input  logic [5*LANES-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*LANES-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [15:0]          cnt
`ifdef C17_MISR_EN
  ,
  output logic [15:0]          sig
`endif
);
  localparam int OW = 2 * LANES;
  // Supplies are carried for netlist compatibility; no behavioural use.
  wire unused_supply = &{1'b0, vdd, gnd};
  logic [OW-1:0]    c17_out;
  logic [DEPTH-1:0] v, ld, sv;
  logic [OW-1:0]    d  [DEPTH];
  logic [OW-1:0]    sd [DEPTH];
  logic             c, in_fire, out_fire;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic i1, i2, i3, i6, i7, n10, n11, n16, n19;
    assign {i7, i6, i3, i2, i1} = in_data[5*k +: 5];
    assign n10 = ~(i1 & i3);
    assign n11 = ~(i3 & i6);
    assign n16 = ~(i2 & n11);
    assign n19 = ~(n11 & i7);
    assign c17_out[2*k +: 2] = {~(n16 & n19), ~(n10 & n16)};
  end
  // A stage loads when it is empty or its contents move on; resolved from the output end backwards.
  always_comb begin
    ld = '0;
    c = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ld[i] = !v[i] || c;
      c = ld[i];
    end
  end
  assign in_ready  = !flush && ld[0];
  assign in_fire   = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_fire  = out_valid && out_ready && !flush;
  for (genvar i = 0; i < DEPTH; i++) begin : g_src
    if (i == 0) begin : g_head
      assign sv[i] = in_fire;
      assign sd[i] = c17_out;
    end else begin : g_body
      assign sv[i] = v[i-1];
      assign sd[i] = d[i-1];
    end
  end
  always_ff @(posedge clk or negedge rn)
    if (!rn) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else if (flush) v <= '0;
    else for (int i = 0; i < DEPTH; i++)
      if (ld[i]) begin
        v[i] <= sv[i];
        d[i] <= sd[i];
      end
  always_ff @(posedge clk or negedge rn)
    if (!rn) cnt <= '0;
    else if (out_fire) cnt <= cnt + 16'd1;
`ifdef C17_MISR_EN
  always_ff @(posedge clk or negedge rn)
    if (!rn) sig <= '0;
    else if (out_fire) sig <= {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ 16'(out_data);
`endif
endmodule
